// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch front end. It holds the program counter, issues one
// instruction-memory request at a time, and fills the IF/ID pipeline register.
// It also handles redirects (trap, MRET, branch, jump), load-use stalls and
// IF/ID flushes.
//
// A redirect that arrives while a request is still outstanding is parked in
// pend/pend_pc. IM_Addr must not move until IM_Ready, so the stale response is
// dropped when it finally lands and fetch restarts at the parked target.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   PcSel             01 branch, 10 jump/jalr, 00/11 sequential
//   Hazard_Stall      load-use stall from decode
//   Hazard_Flush      flush IF/ID to a bubble
//   Branch_Target     redirect target for PcSel=01
//   Jump_Target       redirect target for PcSel=10
//   Trap_Redirect     interrupt/exception taken, target Trap_Vector
//   Mret_Redirect     MRET retiring, target Mepc
//   IM_Req, IM_Addr   fetch request and word-aligned address
//   IM_Ready          one-cycle response strobe; IM_RData is the instruction
//   IF_ID_PC/Instr/Valid  IF/ID pipeline register
//   Fetch_Stall       fetch outstanding; the rest of the pipeline freezes
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PcSel,
    input  logic        Hazard_Stall,
    input  logic        Hazard_Flush,
    input  logic [31:0] Branch_Target,
    input  logic [31:0] Jump_Target,
    input  logic        Trap_Redirect,
    input  logic [31:0] Trap_Vector,
    input  logic        Mret_Redirect,
    input  logic [31:0] Mepc,
    output logic        IM_Req,
    output logic [31:0] IM_Addr,
    input  logic        IM_Ready,
    input  logic [31:0] IM_RData,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid,
    output logic        Fetch_Stall
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        pend, pend_n;
    logic [31:0] pend_pc, pend_pc_n;
    logic [31:0] hold_instr, hold_instr_n;
    logic [31:0] if_id_pc_n, if_id_instr_n;
    logic        if_id_valid_n;

    logic        redirect;
    logic [31:0] target;
    logic        flush;
    logic        load;
    logic [31:0] load_instr;

    // PcSel=11 is not a redirect; it behaves as sequential fetch.
    assign redirect = Trap_Redirect || Mret_Redirect ||
                      (PcSel == 2'b01) || (PcSel == 2'b10);

    always_comb begin
        if (Trap_Redirect)        target = Trap_Vector;
        else if (Mret_Redirect)   target = Mepc;
        else if (PcSel == 2'b01)  target = Branch_Target;
        else                      target = Jump_Target;
    end

    assign IM_Req      = (state == FETCH);
    assign IM_Addr     = {pc[31:2], 2'b00};
    assign Fetch_Stall = (state == FETCH) && !IM_Ready;

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_n      = state;
        pc_n         = pc;
        pend_n       = pend;
        pend_pc_n    = pend_pc;
        hold_instr_n = hold_instr;
        flush        = Hazard_Flush;
        load         = 1'b0;
        load_instr   = IM_RData;

        unique case (state)
            FETCH: begin
                if (!IM_Ready) begin
                    if (redirect) begin
                        // The address must stay put, so the target is parked.
                        pend_n    = 1'b1;
                        pend_pc_n = target;
                        flush     = 1'b1;
                    end
                end else if (pend || redirect) begin
                    // This response belongs to the wrong path, so it is dropped.
                    pc_n   = redirect ? target : pend_pc;
                    pend_n = 1'b0;
                    flush  = 1'b1;
                end else if (Hazard_Stall) begin
                    hold_instr_n = IM_RData;
                    state_n      = HOLD;
                end else begin
                    load = 1'b1;
                    pc_n = pc + 32'd4;
                end
            end
            HOLD: begin
                if (redirect) begin
                    hold_instr_n = '0;
                    pc_n         = target;
                    flush        = 1'b1;
                    state_n      = FETCH;
                end else if (!Hazard_Stall) begin
                    load       = 1'b1;
                    load_instr = hold_instr;
                    pc_n       = pc + 32'd4;
                    state_n    = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase

        // A flush wins over a load. IF_ID_PC keeps its value in both cases
        // except a real load.
        if_id_pc_n    = IF_ID_PC;
        if_id_instr_n = IF_ID_Instr;
        if_id_valid_n = IF_ID_Valid;
        if (flush) begin
            if_id_instr_n = NOP_INSTR;
            if_id_valid_n = 1'b0;
        end else if (load) begin
            if_id_pc_n    = pc;
            if_id_instr_n = load_instr;
            if_id_valid_n = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pend        <= 1'b0;
            pend_pc     <= '0;
            hold_instr  <= '0;
            IF_ID_PC    <= '0;
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_Valid <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pend        <= pend_n;
            pend_pc     <= pend_pc_n;
            hold_instr  <= hold_instr_n;
            IF_ID_PC    <= if_id_pc_n;
            IF_ID_Instr <= if_id_instr_n;
            IF_ID_Valid <= if_id_valid_n;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PcSel;
    logic        Hazard_Stall, Hazard_Flush;
    logic [31:0] Branch_Target, Jump_Target;
    logic        Trap_Redirect, Mret_Redirect;
    logic [31:0] Trap_Vector, Mepc;
    logic        IM_Ready;
    logic [31:0] IM_RData;

    logic        IM_Req, IF_ID_Valid, Fetch_Stall;
    logic [31:0] IM_Addr, IF_ID_PC, IF_ID_Instr;

    // The second instance starts at the top of the address space and
    // shares the stimulus.
    logic        w_IM_Req, w_IF_ID_Valid, w_Fetch_Stall;
    logic [31:0] w_IM_Addr, w_IF_ID_PC, w_IF_ID_Instr;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .PcSel(PcSel),
        .Hazard_Stall(Hazard_Stall), .Hazard_Flush(Hazard_Flush),
        .Branch_Target(Branch_Target), .Jump_Target(Jump_Target),
        .Trap_Redirect(Trap_Redirect), .Trap_Vector(Trap_Vector),
        .Mret_Redirect(Mret_Redirect), .Mepc(Mepc),
        .IM_Req(IM_Req), .IM_Addr(IM_Addr),
        .IM_Ready(IM_Ready), .IM_RData(IM_RData),
        .IF_ID_PC(IF_ID_PC), .IF_ID_Instr(IF_ID_Instr),
        .IF_ID_Valid(IF_ID_Valid), .Fetch_Stall(Fetch_Stall)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .PcSel(PcSel),
        .Hazard_Stall(Hazard_Stall), .Hazard_Flush(Hazard_Flush),
        .Branch_Target(Branch_Target), .Jump_Target(Jump_Target),
        .Trap_Redirect(Trap_Redirect), .Trap_Vector(Trap_Vector),
        .Mret_Redirect(Mret_Redirect), .Mepc(Mepc),
        .IM_Req(w_IM_Req), .IM_Addr(w_IM_Addr),
        .IM_Ready(IM_Ready), .IM_RData(IM_RData),
        .IF_ID_PC(w_IF_ID_PC), .IF_ID_Instr(w_IF_ID_Instr),
        .IF_ID_Valid(w_IF_ID_Valid), .Fetch_Stall(w_Fetch_Stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc,
                              input logic [31:0] instr, input logic valid);
        check({tag, ".pc"}, IF_ID_PC, pc);
        check({tag, ".instr"}, IF_ID_Instr, instr);
        check({tag, ".valid"}, {31'd0, IF_ID_Valid}, {31'd0, valid});
    endtask

    initial begin
        rst = 1'b1;
        PcSel = 2'b00; Hazard_Stall = 1'b0; Hazard_Flush = 1'b0;
        Branch_Target = '0; Jump_Target = '0;
        Trap_Redirect = 1'b0; Trap_Vector = '0;
        Mret_Redirect = 1'b0; Mepc = '0;
        IM_Ready = 1'b1; IM_RData = 32'hBAD0_0000;   // ignored during reset

        // Reset state
        tick(); tick();
        check("rst.req", {31'd0, IM_Req}, 32'd1);
        check("rst.addr", IM_Addr, 32'h0);
        check_ifid("rst", 32'h0, NOP, 1'b0);
        IM_Ready = 1'b0; #1;
        check("rst.fetch_stall", {31'd0, Fetch_Stall}, 32'd1);

        // Back-to-back fetches 0xA0.. with a wrap instance alongside
        rst = 1'b0;
        IM_Ready = 1'b1; IM_RData = 32'hA0;
        tick();
        check_ifid("seq0", 32'h0, 32'hA0, 1'b1);
        check("seq0.addr", IM_Addr, 32'h4);
        check("wrap.ifid_pc", w_IF_ID_PC, 32'hFFFF_FFFC);
        check("wrap.addr", w_IM_Addr, 32'h0);
        IM_RData = 32'hA1; tick();
        check_ifid("seq1", 32'h4, 32'hA1, 1'b1);
        IM_RData = 32'hA2; tick();
        check_ifid("seq2", 32'h8, 32'hA2, 1'b1);
        IM_RData = 32'hA3; tick();
        check("seq3.addr", IM_Addr, 32'h10);

        // Memory latency of 3 cycles at 0x10
        for (int i = 0; i < 3; i++) begin
            IM_Ready = 1'b0; #1;
            check("lat.stall", {31'd0, Fetch_Stall}, 32'd1);
            check("lat.addr", IM_Addr, 32'h10);
            check_ifid("lat", 32'hC, 32'hA3, 1'b1);
            tick();
        end
        IM_Ready = 1'b1; IM_RData = 32'hB0; #1;
        check("lat.release_stall", {31'd0, Fetch_Stall}, 32'd0);
        tick();
        check_ifid("lat.done", 32'h10, 32'hB0, 1'b1);
        check("lat.next_addr", IM_Addr, 32'h14);

        // Branch during an outstanding fetch of 0x14
        IM_Ready = 1'b0; PcSel = 2'b01; Branch_Target = 32'h200;
        tick();
        check_ifid("br.flush", 32'h10, NOP, 1'b0);
        check("br.addr_held", IM_Addr, 32'h14);
        PcSel = 2'b00; Branch_Target = 32'h0;
        tick();
        check("br.gap_valid", {31'd0, IF_ID_Valid}, 32'd0);
        IM_Ready = 1'b1; IM_RData = 32'hDEAD_BEEF;
        tick();
        check("br.addr", IM_Addr, 32'h200);
        check_ifid("br.discard", 32'h10, NOP, 1'b0);

        // Jump together with a response: the response is dropped
        IM_RData = 32'hC0; PcSel = 2'b10; Jump_Target = 32'h20;
        tick();
        check("jmp.addr", IM_Addr, 32'h20);
        check("jmp.valid", {31'd0, IF_ID_Valid}, 32'd0);
        PcSel = 2'b00;

        // Load-use stall coincident with the response at 0x20
        IM_RData = 32'hD0; Hazard_Stall = 1'b1;
        tick();
        IM_Ready = 1'b0; #1;
        check("hold.req", {31'd0, IM_Req}, 32'd0);
        check("hold.fetch_stall", {31'd0, Fetch_Stall}, 32'd0);
        check_ifid("hold1", 32'h10, NOP, 1'b0);
        tick();
        check("hold2.req", {31'd0, IM_Req}, 32'd0);
        check_ifid("hold2", 32'h10, NOP, 1'b0);
        Hazard_Stall = 1'b0;
        tick();
        check_ifid("hold.release", 32'h20, 32'hD0, 1'b1);
        check("hold.next_addr", IM_Addr, 32'h24);
        check("hold.req_back", {31'd0, IM_Req}, 32'd1);

        // Trap beats jump
        IM_Ready = 1'b1; IM_RData = 32'hE0;
        Trap_Redirect = 1'b1; Trap_Vector = 32'h8000;
        PcSel = 2'b10; Jump_Target = 32'h300;
        tick();
        check("trap.addr", IM_Addr, 32'h8000);
        check("trap.valid", {31'd0, IF_ID_Valid}, 32'd0);
        Trap_Redirect = 1'b0; PcSel = 2'b00;

        // MRET beats branch; parked while waiting; unaligned target masked
        IM_Ready = 1'b0; Mret_Redirect = 1'b1; Mepc = 32'h407;
        PcSel = 2'b01; Branch_Target = 32'h999;
        tick();
        check("mret.addr_held", IM_Addr, 32'h8000);
        Mret_Redirect = 1'b0; PcSel = 2'b00;
        IM_Ready = 1'b1; IM_RData = 32'hF00D;
        tick();
        check("mret.addr", IM_Addr, 32'h404);
        check("mret.valid", {31'd0, IF_ID_Valid}, 32'd0);

        // Redirect while in HOLD beats a stall that is still asserted
        IM_RData = 32'hF0; Hazard_Stall = 1'b1;
        tick();
        check("hredir.req_hold", {31'd0, IM_Req}, 32'd0);
        IM_Ready = 1'b0; PcSel = 2'b01; Branch_Target = 32'h600;
        tick();
        check("hredir.req", {31'd0, IM_Req}, 32'd1);
        check("hredir.addr", IM_Addr, 32'h600);
        check("hredir.valid", {31'd0, IF_ID_Valid}, 32'd0);
        PcSel = 2'b00; Hazard_Stall = 1'b0;

        // Normal fetch, then an external flush
        IM_Ready = 1'b1; IM_RData = 32'h11;
        tick();
        check_ifid("pre_flush", 32'h600, 32'h11, 1'b1);
        IM_Ready = 1'b0; Hazard_Flush = 1'b1;
        tick();
        check_ifid("flush", 32'h600, NOP, 1'b0);
        Hazard_Flush = 1'b0;

        // Reset while a fetch of 0x604 is outstanding
        check("pre_rst.addr", IM_Addr, 32'h604);
        rst = 1'b1; #1;
        check("mid_rst.addr", IM_Addr, 32'h0);
        IM_Ready = 1'b1; IM_RData = 32'hBAD1;
        tick();
        rst = 1'b0; IM_RData = 32'h22; #1;
        check("post_rst.req", {31'd0, IM_Req}, 32'd1);
        check("post_rst.addr", IM_Addr, 32'h0);
        check("post_rst.valid", {31'd0, IF_ID_Valid}, 32'd0);
        tick();
        check_ifid("post_rst.fetch", 32'h0, 32'h22, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
